// File: rtl/sprite_anim_rom.sv
// Multi-frame sprite ROM: frame sequencer plus a 2-stage valid-tagged read pipeline with opacity flag.
// Optional macro SPRITE_ANIM_ROM_MIRROR_EN adds a per-request horizontal mirror input.
module sprite_anim_rom #(
  parameter              FILE            = "sprite_anim_rom.dat",
  parameter int          IMG_W           = 16,
  parameter int          IMG_H           = 16,
  parameter int          FRAMES          = 2,
  parameter int          TICKS_PER_FRAME = 30,
  parameter logic [11:0] KEY_RGB         = 12'h000,
  parameter int          XW              = (IMG_W  > 1) ? $clog2(IMG_W)  : 1,
  parameter int          YW              = (IMG_H  > 1) ? $clog2(IMG_H)  : 1,
  parameter int          FW              = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [XW-1:0] req_x,
  input  logic [YW-1:0] req_y,
  input  logic          anim_en,
  input  logic          anim_tick,
  input  logic          frame_load,
  input  logic [FW-1:0] frame_in,
`ifdef SPRITE_ANIM_ROM_MIRROR_EN
  input  logic          mirror,
`endif
  output logic          rsp_valid,
  output logic [11:0]   rsp_rgb,
  output logic          rsp_opaque,
  output logic [FW-1:0] frame_idx
);

  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int DEPTH     = FRAMES * FRAME_PIX;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW        = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  logic [11:0] rom [DEPTH];

  logic [FW-1:0] frame_q, frame_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          v1_q, v1_d;
  logic          r1_q, r1_d;
  logic [AW-1:0] a1_q, a1_d;
  logic          v2_q, v2_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          opq_q, opq_d;

  logic          in_range;
  logic [XW-1:0] col;
  logic [11:0]   rom_data;

  always_comb begin
    frame_d = frame_q;
    tick_d  = tick_q;
    if (frame_load) begin
      tick_d  = '0;
      frame_d = (int'(frame_in) >= FRAMES) ? '0 : frame_in;
    end else if (anim_en && anim_tick) begin
      if (tick_q == CW'(TICKS_PER_FRAME - 1)) begin
        tick_d  = '0;
        frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + FW'(1);
      end else begin
        tick_d = tick_q + CW'(1);
      end
    end
  end

  // Mirroring is applied after the range check so out-of-range stays out of range.
  always_comb begin
    in_range = (int'(req_x) < IMG_W) && (int'(req_y) < IMG_H);
    col      = req_x;
`ifdef SPRITE_ANIM_ROM_MIRROR_EN
    if (mirror) col = XW'(IMG_W - 1) - req_x;
`endif
    v1_d = req_valid;
    r1_d = r1_q;
    a1_d = a1_q;
    if (req_valid) begin
      r1_d = in_range;
      a1_d = in_range ? (AW'(frame_q) * AW'(FRAME_PIX) + AW'(req_y) * AW'(IMG_W) + AW'(col))
                      : '0;
    end
  end

  always_comb begin
    rom_data = rom[a1_q];
    v2_d     = v1_q;
    rgb_d    = rgb_q;
    opq_d    = opq_q;
    if (v1_q) begin
      rgb_d = r1_q ? rom_data : '0;
      opq_d = r1_q && (rom_data != KEY_RGB);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      tick_q  <= '0;
      v1_q    <= 1'b0;
      r1_q    <= 1'b0;
      a1_q    <= '0;
      v2_q    <= 1'b0;
      rgb_q   <= '0;
      opq_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      tick_q  <= tick_d;
      v1_q    <= v1_d;
      r1_q    <= r1_d;
      a1_q    <= a1_d;
      v2_q    <= v2_d;
      rgb_q   <= rgb_d;
      opq_q   <= opq_d;
    end
  end

  assign rsp_valid  = v2_q;
  assign rsp_rgb    = rgb_q;
  assign rsp_opaque = opq_q;
  assign frame_idx  = frame_q;

endmodule

// File: tb/tb_sprite_anim_rom.sv
// Directed bench for sprite_anim_rom: a 16x16x2 instance and a 12x16x3 instance for range/clamp cases.
module tb_sprite_anim_rom;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        req_valid = 0, anim_en = 0, anim_tick = 0, frame_load = 0, mirror = 0;
    logic [3:0]  req_x = 0, req_y = 0;
    logic [0:0]  frame_in = 0;
    logic        rsp_valid, rsp_opaque;
    logic [11:0] rsp_rgb;
    logic [0:0]  frame_idx;

    logic        req_valid2 = 0, anim_en2 = 0, anim_tick2 = 0, frame_load2 = 0, mirror2 = 0;
    logic [3:0]  req_x2 = 0, req_y2 = 0;
    logic [1:0]  frame_in2 = 0;
    logic        rsp_valid2, rsp_opaque2;
    logic [11:0] rsp_rgb2;
    logic [1:0]  frame_idx2;

    int total = 0;
    int bad   = 0;

    sprite_anim_rom #(.IMG_W(16), .IMG_H(16), .FRAMES(2), .TICKS_PER_FRAME(30), .KEY_RGB(12'h000)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .anim_en(anim_en), .anim_tick(anim_tick), .frame_load(frame_load), .frame_in(frame_in),
`ifdef SPRITE_ANIM_ROM_MIRROR_EN
        .mirror(mirror),
`endif
        .rsp_valid(rsp_valid), .rsp_rgb(rsp_rgb), .rsp_opaque(rsp_opaque), .frame_idx(frame_idx)
    );

    sprite_anim_rom #(.IMG_W(12), .IMG_H(16), .FRAMES(3), .TICKS_PER_FRAME(30), .KEY_RGB(12'h000)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_x(req_x2), .req_y(req_y2),
        .anim_en(anim_en2), .anim_tick(anim_tick2), .frame_load(frame_load2), .frame_in(frame_in2),
`ifdef SPRITE_ANIM_ROM_MIRROR_EN
        .mirror(mirror2),
`endif
        .rsp_valid(rsp_valid2), .rsp_rgb(rsp_rgb2), .rsp_opaque(rsp_opaque2), .frame_idx(frame_idx2)
    );

    // Reference image: a few hand-placed landmark pixels, a ramp elsewhere (never zero for i < 585).
    function automatic logic [11:0] pix(input int i);
        if (i == 35)  return 12'hF0F;
        if (i == 5)   return 12'h000;
        if (i == 256) return 12'hABC;
        return 12'(i * 7 + 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        anim_tick = 1'b1;
        step();
        anim_tick = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", rsp_rgb); end
        total++; if (rsp_opaque !== 1'b0) begin bad++; $display("FAIL reset_opaque got=%b exp=0", rsp_opaque); end
        total++; if (frame_idx !== 1'b0) begin bad++; $display("FAIL reset_frame got=%0d exp=0", frame_idx); end
        total++; if (rsp_valid2 !== 1'b0) begin bad++; $display("FAIL reset_valid2 got=%b exp=0", rsp_valid2); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_latency();
        req_valid = 1; req_x = 3; req_y = 2;
        step();
        req_valid = 0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", rsp_valid); end
        step();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", rsp_valid); end
        total++; if (rsp_rgb !== 12'hF0F) begin bad++; $display("FAIL lat_rgb got=%h exp=f0f", rsp_rgb); end
        total++; if (rsp_opaque !== 1'b1) begin bad++; $display("FAIL lat_opaque got=%b exp=1", rsp_opaque); end
        total++; if (frame_idx !== 1'b0) begin bad++; $display("FAIL lat_frame got=%0d exp=0", frame_idx); end
        step();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_rgb !== 12'hF0F) begin bad++; $display("FAIL hold_rgb got=%h exp=f0f", rsp_rgb); end
    endtask

    task automatic test_stream();
        logic [11:0] e;
        req_y = 0;
        for (int c = 0; c < 18; c++) begin
            req_valid = (c < 16);
            req_x     = 4'(c);
            step();
            if (c >= 1 && c <= 16) begin
                e = pix(c - 1);
                total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", c - 1, rsp_valid); end
                total++; if (rsp_rgb !== e) begin bad++; $display("FAIL stream_rgb[%0d] got=%h exp=%h", c - 1, rsp_rgb, e); end
                total++; if (rsp_opaque !== (e != 12'h000)) begin bad++; $display("FAIL stream_opaque[%0d] got=%b exp=%b", c - 1, rsp_opaque, e != 12'h000); end
            end else if (c == 17) begin
                total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b exp=0", rsp_valid); end
            end
        end
    endtask

    task automatic test_anim();
        anim_en = 1;
        repeat (29) pulse();
        total++; if (frame_idx !== 1'b0) begin bad++; $display("FAIL anim_29 got=%0d exp=0", frame_idx); end
        pulse();
        total++; if (frame_idx !== 1'b1) begin bad++; $display("FAIL anim_30 got=%0d exp=1", frame_idx); end
        req_valid = 1; req_x = 0; req_y = 0;
        step();
        req_valid = 0;
        step();
        total++; if (rsp_rgb !== 12'hABC) begin bad++; $display("FAIL anim_frame1_rgb got=%h exp=abc", rsp_rgb); end
        repeat (30) pulse();
        total++; if (frame_idx !== 1'b0) begin bad++; $display("FAIL anim_wrap got=%0d exp=0", frame_idx); end
    endtask

    task automatic test_frame_change_request();
        repeat (29) pulse();
        anim_tick = 1; req_valid = 1; req_x = 0; req_y = 0;
        step();
        anim_tick = 0;
        step();
        req_valid = 0;
        total++; if (rsp_rgb !== 12'h001) begin bad++; $display("FAIL chg_old_frame got=%h exp=001", rsp_rgb); end
        total++; if (frame_idx !== 1'b1) begin bad++; $display("FAIL chg_frame got=%0d exp=1", frame_idx); end
        step();
        total++; if (rsp_rgb !== 12'hABC) begin bad++; $display("FAIL chg_new_frame got=%h exp=abc", rsp_rgb); end
    endtask

    task automatic test_priority();
        repeat (10) pulse();
        anim_tick = 1; frame_load = 1; frame_in = 1;
        step();
        anim_tick = 0; frame_load = 0;
        step();
        total++; if (frame_idx !== 1'b1) begin bad++; $display("FAIL prio_load got=%0d exp=1", frame_idx); end
        repeat (29) pulse();
        total++; if (frame_idx !== 1'b1) begin bad++; $display("FAIL prio_cnt_clear got=%0d exp=1", frame_idx); end
        pulse();
        total++; if (frame_idx !== 1'b0) begin bad++; $display("FAIL prio_adv got=%0d exp=0", frame_idx); end
        repeat (5) pulse();
        anim_en = 0;
        repeat (40) pulse();
        total++; if (frame_idx !== 1'b0) begin bad++; $display("FAIL dis_hold got=%0d exp=0", frame_idx); end
        anim_en = 1;
        repeat (24) pulse();
        total++; if (frame_idx !== 1'b0) begin bad++; $display("FAIL dis_cnt_hold got=%0d exp=0", frame_idx); end
        pulse();
        total++; if (frame_idx !== 1'b1) begin bad++; $display("FAIL dis_resume got=%0d exp=1", frame_idx); end
        anim_en = 0;
    endtask

    task automatic test_clamp();
        frame_load2 = 1; frame_in2 = 2;
        step();
        frame_load2 = 0;
        total++; if (frame_idx2 !== 2'd2) begin bad++; $display("FAIL clamp_load2 got=%0d exp=2", frame_idx2); end
        frame_load2 = 1; frame_in2 = 3;
        step();
        frame_load2 = 0;
        total++; if (frame_idx2 !== 2'd0) begin bad++; $display("FAIL clamp_load3 got=%0d exp=0", frame_idx2); end
    endtask

    task automatic test_out_of_range();
        req_valid2 = 1; req_x2 = 11; req_y2 = 1;
        step();
        req_x2 = 13; req_y2 = 0;
        step();
        req_valid2 = 0;
        total++; if (rsp_rgb2 !== 12'h0A2) begin bad++; $display("FAIL oor_inrange_rgb got=%h exp=0a2", rsp_rgb2); end
        total++; if (rsp_opaque2 !== 1'b1) begin bad++; $display("FAIL oor_inrange_opaque got=%b exp=1", rsp_opaque2); end
        step();
        total++; if (rsp_valid2 !== 1'b1) begin bad++; $display("FAIL oor_valid got=%b exp=1", rsp_valid2); end
        total++; if (rsp_rgb2 !== 12'h000) begin bad++; $display("FAIL oor_rgb got=%h exp=000", rsp_rgb2); end
        total++; if (rsp_opaque2 !== 1'b0) begin bad++; $display("FAIL oor_opaque got=%b exp=0", rsp_opaque2); end
    endtask

    task automatic test_reset_midstream();
        req_valid = 1; req_x = 3; req_y = 2;
        step();
        req_valid = 0;
        rst = 1;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_rgb !== 12'h000) begin bad++; $display("FAIL mrst_rgb got=%h exp=000", rsp_rgb); end
        total++; if (rsp_opaque !== 1'b0) begin bad++; $display("FAIL mrst_opaque got=%b exp=0", rsp_opaque); end
        total++; if (frame_idx !== 1'b0) begin bad++; $display("FAIL mrst_frame got=%0d exp=0", frame_idx); end
        step();
        step();
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mrst_after[%0d] got=%b exp=0", c, rsp_valid); end
        end
    endtask

`ifdef SPRITE_ANIM_ROM_MIRROR_EN
    task automatic test_mirror();
        req_valid = 1; req_x = 0; req_y = 0; mirror = 1;
        step();
        req_valid = 0; mirror = 0;
        step();
        total++; if (rsp_rgb !== 12'h06A) begin bad++; $display("FAIL mirror_rgb got=%h exp=06a", rsp_rgb); end
    endtask
`endif

    initial begin
        #1;
        for (int i = 0; i < 512; i++) dut.rom[i] = pix(i);
        for (int i = 0; i < 576; i++) dut2.rom[i] = pix(i);
        test_reset();
        test_latency();
        test_stream();
        test_anim();
        test_frame_change_request();
        test_priority();
        test_clamp();
        test_out_of_range();
        test_reset_midstream();
`ifdef SPRITE_ANIM_ROM_MIRROR_EN
        test_mirror();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
